// File: rtl/out_drain_if.sv
// out_drain_if: array-output and SRAMC write-port signals of out_drain
interface out_drain_if #(
   parameter int Y = 3,
   parameter int OC_W = 32,
   parameter int SRAMC_W = 128,
   parameter int ADRC_W = 8,
   parameter int CNT_W = 11
);
   localparam int SRAMC_N = SRAMC_W / OC_W;
   logic                     i_clear;
   logic                     i_pipeline_en;
   logic [0:Y-1][OC_W-1:0]   i_c_arr;
   logic                     i_valid;
   logic [0:Y-1]             i_rows_active;
   logic [ADRC_W-1:0]        i_base;
   logic [ADRC_W-1:0]        i_step;
   logic [CNT_W-1:0]         i_nwrites;
   logic                     i_sramc_gnt;
   logic                     o_sramc_wren;
   logic [ADRC_W-1:0]        o_sramc_addr;
   logic [SRAMC_W-1:0]       o_sramc_data;
   logic [SRAMC_N-1:0]       o_sramc_wmask;
   logic                     o_full;
   logic                     o_empty;
   logic                     o_overflow;
   logic                     o_done;
   modport slave (
      input  i_clear, i_pipeline_en, i_c_arr, i_valid, i_rows_active,
             i_base, i_step, i_nwrites, i_sramc_gnt,
      output o_sramc_wren, o_sramc_addr, o_sramc_data, o_sramc_wmask,
             o_full, o_empty, o_overflow, o_done
   );
   modport master (
      output i_clear, i_pipeline_en, i_c_arr, i_valid, i_rows_active,
             i_base, i_step, i_nwrites, i_sramc_gnt,
      input  o_sramc_wren, o_sramc_addr, o_sramc_data, o_sramc_wmask,
             o_full, o_empty, o_overflow, o_done
   );
endinterface

// File: rtl/out_drain.sv
// out_drain: deskews array row outputs, buffers aligned vectors, writes them to SRAMC
module out_drain #(
   parameter int Y = 3,
   parameter int OC_W = 32,
   parameter int SRAMC_W = 128,
   parameter int ADRC_W = 8,
   parameter int FIFO_POSITIONS = 4,
   parameter int CNT_W = 11
) (
   input  logic       i_clk,
   input  logic       i_rstn,
   out_drain_if.slave bus
);
   localparam int SRAMC_N = SRAMC_W / OC_W;
   localparam int PW = $clog2(FIFO_POSITIONS);
   localparam int CW = $clog2(FIFO_POSITIONS + 1);
   localparam int VW = Y * OC_W + Y;

   if (Y > SRAMC_N) begin : g_chk_y
      $error("out_drain: Y exceeds SRAMC_W/OC_W");
   end
   if (FIFO_POSITIONS < 2) begin : g_chk_fifo
      $error("out_drain: FIFO_POSITIONS must be at least 2");
   end

   logic [Y*OC_W-1:0] al_data;
   logic [Y-1:0]      act;
   logic              vec_valid;

   // row y is delayed by Y-1-y enabled cycles so all rows line up with row Y-1
   for (genvar y = 0; y < Y; y++) begin : g_row
      assign act[y] = bus.i_rows_active[y];
      if (y == Y - 1) begin : g_direct
         assign al_data[y*OC_W +: OC_W] = bus.i_c_arr[y];
      end else begin : g_skew
         logic [OC_W-1:0] sr [Y-1-y];
         always_ff @(posedge i_clk or negedge i_rstn)
            if (!i_rstn) sr <= '{default: '0};
            else if (bus.i_clear) sr <= '{default: '0};
            else if (bus.i_pipeline_en) begin
               sr[0] <= bus.i_c_arr[y];
               for (int i = 1; i < Y - 1 - y; i++) sr[i] <= sr[i-1];
            end
         assign al_data[y*OC_W +: OC_W] = sr[Y-2-y];
      end
   end

   if (Y == 1) begin : g_v_direct
      assign vec_valid = bus.i_valid;
   end else begin : g_v_skew
      logic [Y-2:0] vsr;
      always_ff @(posedge i_clk or negedge i_rstn)
         if (!i_rstn) vsr <= '0;
         else if (bus.i_clear) vsr <= '0;
         else if (bus.i_pipeline_en) vsr <= (vsr << 1) | (Y-1)'(bus.i_valid);
      assign vec_valid = vsr[Y-2];
   end

   logic [VW-1:0]     mem [FIFO_POSITIONS];
   logic [PW-1:0]     wp, rp;
   logic [CW-1:0]     cnt;
   logic [CNT_W-1:0]  wcnt;
   logic [ADRC_W-1:0] addr;
   logic              ovf, done;
   logic              full, empty, wren, pop, push_req, push;
   logic [VW-1:0]     head;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_POSITIONS - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full     = cnt == CW'(FIFO_POSITIONS);
   assign empty    = cnt == '0;
   assign wren     = !empty && !done;
   assign pop      = wren && bus.i_sramc_gnt;
   assign push_req = bus.i_pipeline_en && vec_valid;
   // a pop on the same edge frees the slot, so a full FIFO can still accept
   assign push     = push_req && (!full || pop);
   assign head     = mem[rp];

   always_ff @(posedge i_clk)
      if (push && !bus.i_clear) mem[wp] <= {act, al_data};

   always_ff @(posedge i_clk or negedge i_rstn)
      if (!i_rstn) begin
         wp   <= '0;
         rp   <= '0;
         cnt  <= '0;
         wcnt <= '0;
         addr <= '0;
         ovf  <= 1'b0;
         done <= 1'b0;
      end else if (bus.i_clear) begin
         wp   <= '0;
         rp   <= '0;
         cnt  <= '0;
         wcnt <= '0;
         addr <= bus.i_base;
         ovf  <= 1'b0;
         done <= 1'b0;
      end else begin
         if (push) wp <= inc(wp);
         if (pop) begin
            rp   <= inc(rp);
            addr <= addr + bus.i_step;
            wcnt <= wcnt + 1'b1;
         end
         cnt  <= cnt + CW'(push) - CW'(pop);
         ovf  <= ovf || (push_req && full && !pop);
         done <= done || (wcnt + CNT_W'(pop) == bus.i_nwrites);
      end

   assign bus.o_sramc_wren  = wren;
   assign bus.o_sramc_addr  = addr;
   assign bus.o_sramc_data  = wren ? SRAMC_W'(head[Y*OC_W-1:0]) : '0;
   assign bus.o_sramc_wmask = wren ? SRAMC_N'(head[VW-1 -: Y]) : '0;
   assign bus.o_full        = full;
   assign bus.o_empty       = empty;
   assign bus.o_overflow    = ovf;
   assign bus.o_done        = done;
endmodule

// File: tb/tb_out_drain.sv
// tb_out_drain: random and directed stimulus checked against a queue-based reference model
module tb_out_drain;
   localparam int Y = 3, OC_W = 32, SRAMC_W = 128, ADRC_W = 8, FP = 4, CNT_W = 11, N = 4;

   logic clk = 1'b0;
   logic rstn = 1'b1;
   always #5 clk = ~clk;

   out_drain_if #(.Y(Y), .OC_W(OC_W), .SRAMC_W(SRAMC_W), .ADRC_W(ADRC_W), .CNT_W(CNT_W)) bus ();
   out_drain #(.Y(Y), .OC_W(OC_W), .SRAMC_W(SRAMC_W), .ADRC_W(ADRC_W),
      .FIFO_POSITIONS(FP), .CNT_W(CNT_W)) dut (.i_clk(clk), .i_rstn(rstn), .bus(bus));

   int checks = 0;
   int errors = 0;

   typedef struct { logic [SRAMC_W-1:0] data; logic [N-1:0] mask; } ent_t;
   typedef struct { logic [0:Y-1][OC_W-1:0] c; logic v; } smp_t;
   typedef struct { logic [ADRC_W-1:0] addr; logic [SRAMC_W-1:0] data; logic [N-1:0] mask; } wr_t;

   ent_t q[$];
   smp_t hist[$];
   wr_t  log_q[$];
   logic [ADRC_W-1:0] m_addr = '0;
   int   m_wcnt;
   logic m_done, m_ovf;

   task automatic chk(string n, logic [127:0] a, logic [127:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", n, a, e);
      end
   endtask

   function automatic logic [SRAMC_W-1:0] word(int k);
      logic [SRAMC_W-1:0] w = '0;
      for (int y = 0; y < Y; y++) w[y*OC_W +: OC_W] = OC_W'(100 * k + y);
      return w;
   endfunction

   task automatic mzero();
      smp_t z;
      z.c = '0;
      z.v = 1'b0;
      q.delete();
      hist.delete();
      for (int i = 0; i < Y - 1; i++) hist.push_back(z);
      m_wcnt = 0;
      m_done = 1'b0;
      m_ovf = 1'b0;
   endtask

   // reference model: hist[0] is the sample taken one enabled edge ago
   initial begin
      mzero();
      forever begin
         ent_t e;
         smp_t s;
         bit pop, was_full, pv;
         @(posedge clk or negedge rstn);
         if (!rstn) begin
            mzero();
            m_addr = '0;
         end else if (bus.i_clear) begin
            mzero();
            m_addr = bus.i_base;
         end else begin
            was_full = q.size() == FP;
            pop = q.size() > 0 && !m_done && bus.i_sramc_gnt;
            pv = 1'b0;
            e.data = '0;
            e.mask = '0;
            if (bus.i_pipeline_en) begin
               pv = hist[Y-2].v;
               for (int y = 0; y < Y; y++) begin
                  if (y == Y - 1) e.data[y*OC_W +: OC_W] = bus.i_c_arr[y];
                  else e.data[y*OC_W +: OC_W] = hist[Y-2-y].c[y];
                  e.mask[y] = bus.i_rows_active[y];
               end
               s.c = bus.i_c_arr;
               s.v = bus.i_valid;
               hist.push_front(s);
               void'(hist.pop_back());
            end
            if (pop) begin
               void'(q.pop_front());
               m_addr = m_addr + bus.i_step;
               m_wcnt++;
            end
            if (pv) begin
               if (was_full && !pop) m_ovf = 1'b1;
               else q.push_back(e);
            end
            if (m_wcnt == int'(bus.i_nwrites)) m_done = 1'b1;
         end
      end
   end

   // compare DUT against model every cycle
   initial forever begin
      logic w;
      @(negedge clk);
      w = q.size() > 0 && !m_done;
      chk("wren", bus.o_sramc_wren, w);
      chk("addr", bus.o_sramc_addr, m_addr);
      chk("data", bus.o_sramc_data, w ? q[0].data : '0);
      chk("wmask", bus.o_sramc_wmask, w ? q[0].mask : '0);
      chk("full", bus.o_full, q.size() == FP);
      chk("empty", bus.o_empty, q.size() == 0);
      chk("overflow", bus.o_overflow, m_ovf);
      chk("done", bus.o_done, m_done);
   end

   initial forever begin
      wr_t r;
      @(negedge clk);
      if (rstn && bus.o_sramc_wren === 1'b1 && bus.i_sramc_gnt === 1'b1) begin
         r.addr = bus.o_sramc_addr;
         r.data = bus.o_sramc_data;
         r.mask = bus.o_sramc_wmask;
         log_q.push_back(r);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic ctx(logic [7:0] b, logic [7:0] s, logic [10:0] nw, logic [2:0] act);
      bus.i_clear = 1'b1;
      bus.i_base = b;
      bus.i_step = s;
      bus.i_nwrites = nw;
      bus.i_rows_active = act;
      bus.i_valid = 1'b0;
      bus.i_pipeline_en = 1'b0;
      bus.i_c_arr = '0;
      cyc();
      bus.i_clear = 1'b0;
      log_q.delete();
   endtask

   // row y of vector k is presented y cycles after row 0, carrying 100*k+y
   task automatic drive_vecs(int n, int kb);
      for (int t = 0; t < n + Y - 1; t++) begin
         bus.i_pipeline_en = 1'b1;
         bus.i_valid = t < n;
         for (int y = 0; y < Y; y++)
            bus.i_c_arr[y] = (t - y >= 0 && t - y < n) ? OC_W'(100 * (kb + t - y) + y) : '0;
         cyc();
      end
      bus.i_valid = 1'b0;
      bus.i_c_arr = '0;
   endtask

   task automatic chk_writes(string n, int cnt, logic [7:0] a0, logic [7:0] st, int kb, logic [3:0] m);
      chk({n, " count"}, log_q.size(), cnt);
      for (int k = 0; k < cnt && k < log_q.size(); k++) begin
         chk({n, " addr"}, log_q[k].addr, 8'(a0 + k * st));
         chk({n, " data"}, log_q[k].data, word(kb + k));
         chk({n, " mask"}, log_q[k].mask, m);
      end
   endtask

   initial begin
      bus.i_clear = 1'b0;
      bus.i_pipeline_en = 1'b0;
      bus.i_c_arr = '0;
      bus.i_valid = 1'b0;
      bus.i_rows_active = '0;
      bus.i_base = '0;
      bus.i_step = '0;
      bus.i_nwrites = '0;
      bus.i_sramc_gnt = 1'b0;
      #1 rstn = 1'b0;
      #1;
      chk("rst wren", bus.o_sramc_wren, 0);
      chk("rst addr", bus.o_sramc_addr, 0);
      chk("rst empty", bus.o_empty, 1);
      chk("rst full", bus.o_full, 0);
      repeat (2) cyc();
      rstn = 1'b1;

      // basic four-vector context
      ctx(8'h10, 8'd1, 11'd4, 3'b111);
      bus.i_sramc_gnt = 1'b1;
      drive_vecs(4, 0);
      repeat (4) cyc();
      chk_writes("basic", 4, 8'h10, 8'd1, 0, 4'b0111);
      chk("basic done", bus.o_done, 1);

      // back-pressure and overflow
      ctx(8'h00, 8'd1, 11'd8, 3'b111);
      bus.i_sramc_gnt = 1'b0;
      drive_vecs(4, 0);
      chk("bp full", bus.o_full, 1);
      chk("bp ovf0", bus.o_overflow, 0);
      drive_vecs(1, 4);
      chk("bp ovf1", bus.o_overflow, 1);
      chk("bp full2", bus.o_full, 1);
      bus.i_sramc_gnt = 1'b1;
      repeat (6) cyc();
      chk_writes("bp", 4, 8'h00, 8'd1, 0, 4'b0111);

      // stall between row-1 and row-2 arrival
      ctx(8'h00, 8'd1, 11'd1, 3'b111);
      bus.i_sramc_gnt = 1'b1;
      bus.i_pipeline_en = 1'b1;
      bus.i_valid = 1'b1;
      bus.i_c_arr[0] = 32'hA0;
      cyc();
      bus.i_valid = 1'b0;
      bus.i_c_arr[0] = '0;
      bus.i_c_arr[1] = 32'hA1;
      cyc();
      bus.i_pipeline_en = 1'b0;
      repeat (2) cyc();
      chk("stall empty", bus.o_empty, 1);
      bus.i_pipeline_en = 1'b1;
      bus.i_c_arr[1] = '0;
      bus.i_c_arr[2] = 32'hA2;
      cyc();
      chk("stall wren", bus.o_sramc_wren, 1);
      bus.i_c_arr[2] = '0;
      repeat (3) cyc();
      chk("stall count", log_q.size(), 1);
      if (log_q.size() > 0) chk("stall data", log_q[0].data, {32'h0, 32'hA2, 32'hA1, 32'hA0});

      // address wrap
      ctx(8'hFE, 8'd3, 11'd3, 3'b111);
      drive_vecs(3, 0);
      repeat (4) cyc();
      chk_writes("wrap", 3, 8'hFE, 8'd3, 0, 4'b0111);
      if (log_q.size() == 3) chk("wrap addr1", log_q[1].addr, 8'h01);
      chk("wrap done", bus.o_done, 1);

      // row masking
      ctx(8'h40, 8'd1, 11'd2, 3'b101);
      drive_vecs(2, 7);
      repeat (3) cyc();
      chk_writes("mask", 2, 8'h40, 8'd1, 7, 4'b0101);

      // zero writes
      ctx(8'h50, 8'd1, 11'd0, 3'b111);
      cyc();
      chk("nw0 done", bus.o_done, 1);
      drive_vecs(1, 0);
      repeat (3) cyc();
      chk("nw0 count", log_q.size(), 0);

      // clear with buffered entries
      ctx(8'h20, 8'd1, 11'd8, 3'b111);
      bus.i_sramc_gnt = 1'b0;
      drive_vecs(2, 0);
      chk("clr pre empty", bus.o_empty, 0);
      ctx(8'h20, 8'd1, 11'd8, 3'b111);
      bus.i_sramc_gnt = 1'b1;
      chk("clr empty", bus.o_empty, 1);
      chk("clr addr", bus.o_sramc_addr, 8'h20);
      repeat (3) cyc();
      chk("clr count", log_q.size(), 0);

      // async reset while a write is pending
      ctx(8'h30, 8'd1, 11'd8, 3'b111);
      bus.i_sramc_gnt = 1'b0;
      drive_vecs(1, 0);
      chk("ar wren1", bus.o_sramc_wren, 1);
      bus.i_sramc_gnt = 1'b1;
      #2 rstn = 1'b0;
      #1;
      chk("ar wren", bus.o_sramc_wren, 0);
      chk("ar addr", bus.o_sramc_addr, 0);
      chk("ar data", bus.o_sramc_data, 0);
      chk("ar mask", bus.o_sramc_wmask, 0);
      chk("ar empty", bus.o_empty, 1);
      chk("ar done", bus.o_done, 0);
      cyc();
      rstn = 1'b1;

      // randomized contexts
      for (int c = 0; c < 40; c++) begin
         ctx(8'($urandom), 8'($urandom), 11'($urandom_range(0, 12)), 3'($urandom));
         for (int i = 0; i < 60; i++) begin
            bus.i_pipeline_en = ($urandom % 4) != 0;
            bus.i_valid = 1'($urandom);
            for (int y = 0; y < Y; y++) bus.i_c_arr[y] = $urandom;
            bus.i_sramc_gnt = ($urandom % 3) != 0;
            cyc();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
